// File: rtl/channel_arbiter.sv
// Round-robin arbiter: N two-phase input channels onto one two-phase output; 1-edge grant latency.
// A flit is held on out_data/out_req until out_ack matches out_req, with no timeout.
module channel_arbiter #(
  parameter int N    = 4,
  parameter int SIZE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      in_req,
  output logic [N-1:0]      in_ack,
  input  logic [N*SIZE-1:0] in_data,
  output logic              out_req,
  input  logic              out_ack,
  output logic [SIZE-1:0]   out_data,
  output logic [2:0]        grant_id,
  output logic              busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]      state;
  logic [2:0]      last_grant;
  logic [N-1:0]    pending;
  logic [N-1:0]    ack_flip;
  logic            win_vld;
  logic [2:0]      win_idx;
  logic [3:0]      cand;
  logic [SIZE-1:0] win_data;

  assign pending = in_req ^ in_ack;
  assign busy    = (state == BUSY);

  // Walk offsets 1..N from the last grant; the first pending candidate wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_grant} + 4'(k);
      if (cand >= 4'(N))
        cand = cand - 4'(N);
      for (int i = 0; i < N; i++) begin
        if (!win_vld && pending[i] && (cand == 4'(i))) begin
          win_vld = 1'b1;
          win_idx = 3'(i);
        end
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == 3'(i))
        win_data = in_data[i*SIZE +: SIZE];
    end
  end

  always_comb begin
    ack_flip = '0;
    for (int i = 0; i < N; i++)
      ack_flip[i] = (grant_id == 3'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      out_req    <= 1'b0;
      out_data   <= '0;
      in_ack     <= '0;
      grant_id   <= '0;
      last_grant <= 3'(N - 1);
    end else if (state == IDLE) begin
      if (win_vld) begin
        out_data <= win_data;
        out_req  <= ~out_req;
        grant_id <= win_idx;
        state    <= BUSY;
      end
    end else begin
      if (out_ack == out_req) begin
        in_ack     <= in_ack ^ ack_flip;
        last_grant <= grant_id;
        state      <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_channel_arbiter.sv
// Randomized and directed bench for channel_arbiter against a transaction-level reference model.
module tb_channel_arbiter;
  localparam int N    = 4;
  localparam int SIZE = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      in_req;
  logic [N-1:0]      in_ack;
  logic [N*SIZE-1:0] in_data;
  logic              out_req;
  logic              out_ack;
  logic [SIZE-1:0]   out_data;
  logic [2:0]        grant_id;
  logic              busy;

  channel_arbiter #(.N(N), .SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
    .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  // reference model state
  logic            m_req;
  logic [N-1:0]    m_ack;
  logic [SIZE-1:0] m_data;
  int              m_gid;
  int              m_last;
  bit              m_busy;

  int          obs_gid[$];
  int          obs_dat[$];
  logic        prev_req;
  int          ack_mode;
  logic [N-1:0] rereq_mask;
  bit          rand_req;
  logic [7:0]  e30[4] = '{8'h10, 8'h21, 8'h32, 8'h43};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req  = 1'b0;
    m_ack  = '0;
    m_data = '0;
    m_gid  = 0;
    m_last = N - 1;
    m_busy = 1'b0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (in_req[c] != m_ack[c]) begin
          m_data = in_data[c*SIZE +: SIZE];
          m_req  = ~m_req;
          m_gid  = c;
          m_busy = 1'b1;
          break;
        end
      end
    end else if (out_ack == m_req) begin
      m_ack[m_gid] = ~m_ack[m_gid];
      m_last       = m_gid;
      m_busy       = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("out_req", 32'(out_req), 32'(m_req));
    check("out_data", 32'(out_data), 32'(m_data));
    check("grant_id", 32'(grant_id), 32'(m_gid));
    check("busy", 32'(busy), 32'(m_busy));
    check("in_ack", 32'(in_ack), 32'(m_ack));
  endtask

  // Every new request goes through here so a premature re-toggle is caught.
  task automatic toggle(input int i, input logic [SIZE-1:0] d);
    if (in_req[i] != in_ack[i]) begin
      viol++;
      $display("protocol violation: input %0d toggled before its acknowledge", i);
    end
    in_data[i*SIZE +: SIZE] = d;
    in_req[i] = ~in_req[i];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    if (out_req != prev_req) begin
      obs_gid.push_back(int'(grant_id));
      obs_dat.push_back(int'(out_data));
    end
    prev_req = out_req;
    if (ack_mode == 1)
      out_ack = out_req;
    else if (ack_mode == 2 && $urandom_range(1, 0) == 1)
      out_ack = out_req;
    for (int i = 0; i < N; i++)
      if (rereq_mask[i] && in_req[i] == in_ack[i])
        toggle(i, SIZE'($urandom));
    if (rand_req) begin
      for (int i = 0; i < N; i++) begin
        if (in_req[i] == in_ack[i] && $urandom_range(3, 0) == 0)
          toggle(i, SIZE'($urandom));
        else
          in_data[i*SIZE +: SIZE] = SIZE'($urandom);
      end
    end
  endtask

  task automatic clear_obs();
    obs_gid.delete();
    obs_dat.delete();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    in_req     = '0;
    out_ack    = 1'b0;
    ack_mode   = 0;
    rereq_mask = '0;
    rand_req   = 1'b0;
    #1;
    model_reset();
    compare_all();
    tick();
    tick();
    reset    = 1'b0;
    prev_req = 1'b0;
    clear_obs();
  endtask

  task automatic wait_grants(input int n, input int budget);
    int c = 0;
    while (obs_gid.size() < n && c < budget) begin
      tick();
      c++;
    end
    check("grant_count", 32'(obs_gid.size() >= n), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while ((busy || in_req != in_ack) && c < budget) begin
      tick();
      c++;
    end
    check("drain", 32'({busy, in_req ^ in_ack}), 32'd0);
  endtask

  function automatic int obs_g(input int k);
    return (k < obs_gid.size()) ? obs_gid[k] : -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    in_req  = '0;
    in_data = '0;
    out_ack = 1'b0;
    prev_req = 1'b0;
    do_reset();

    // single request on input 2
    toggle(2, 8'h5A);
    tick();
    check("single_data", 32'(out_data), 32'h5A);
    check("single_req", 32'(out_req), 32'd1);
    check("single_gid", 32'(grant_id), 32'd2);
    check("single_busy", 32'(busy), 32'd1);
    out_ack = 1'b1;
    tick();
    check("single_ack2", 32'(in_ack[2]), 32'd1);
    check("single_idle", 32'(busy), 32'd0);
    tick();

    // simultaneous requests after reset
    do_reset();
    for (int i = 0; i < N; i++) toggle(i, e30[i]);
    ack_mode = 1;
    wait_grants(4, 40);
    wait_drain(20);
    for (int k = 0; k < 4; k++) begin
      check("simul_gid", 32'(obs_g(k)), 32'(k));
      check("simul_data", 32'((k < obs_dat.size()) ? obs_dat[k] : -1), 32'(e30[k]));
    end

    // fairness between inputs 1 and 3
    clear_obs();
    rereq_mask = 4'b1010;
    toggle(1, SIZE'($urandom));
    toggle(3, SIZE'($urandom));
    wait_grants(8, 100);
    for (int k = 0; k < 8; k++)
      check("fair_gid", 32'(obs_g(k)), (k % 2 == 0) ? 32'd1 : 32'd3);
    rereq_mask = '0;
    wait_drain(40);

    // stalled output channel
    ack_mode = 0;
    toggle(0, 8'hC3);
    tick();
    check("stall_gid", 32'(grant_id), 32'd0);
    for (int c = 0; c < 50; c++) begin
      for (int i = 1; i < N; i++)
        if (in_req[i] == in_ack[i] && $urandom_range(1, 0) == 1)
          toggle(i, SIZE'($urandom));
      for (int i = 0; i < N; i++)
        if (in_req[i] != in_ack[i] || i == 0)
          in_data[i*SIZE +: SIZE] = SIZE'($urandom);
      tick();
    end
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_data", 32'(out_data), 32'hC3);
    check("stall_inack", 32'(in_ack[0]), 32'(m_ack[0]));
    ack_mode = 1;
    wait_drain(40);

    // reset while busy serving input 1
    ack_mode = 0;
    toggle(1, 8'h77);
    tick();
    check("rst_pre_gid", 32'(grant_id), 32'd1);
    check("rst_pre_busy", 32'(busy), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_req", 32'(out_req), 32'd0);
    check("rst_inack", 32'(in_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    in_req = 4'b1100;
    prev_req = 1'b0;
    clear_obs();
    tick();
    check("rst_held_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    check("rst_first_gid", 32'(grant_id), 32'd2);
    ack_mode = 1;
    wait_drain(40);

    // wrap-around from last_grant = 3
    do_reset();
    ack_mode = 1;
    toggle(3, 8'h33);
    wait_drain(20);
    clear_obs();
    toggle(0, 8'hA0);
    toggle(2, 8'hA2);
    wait_grants(2, 20);
    check("wrap_first", 32'(obs_g(0)), 32'd0);
    check("wrap_second", 32'(obs_g(1)), 32'd2);
    wait_drain(20);

    // randomized traffic with a randomly responding output channel
    do_reset();
    ack_mode = 2;
    rand_req = 1'b1;
    repeat (3000) tick();
    rand_req = 1'b0;
    ack_mode = 1;
    wait_drain(100);

    check("protocol_violations", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/channel_arbiter.md
CHANNEL_ARBITER -- requirements
Module: channel_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesting input channels (legal range 2..8).
REQ-002 SHALL have parameter SIZE, default 8, meaning flit width in bits (destination plus payload).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_req  input  N  per-input two-phase request; a toggle marks a new flit.
REQ-006 SHALL have port in_ack  output  N  per-input two-phase acknowledge, registered.
REQ-007 SHALL have port in_data  input  N*SIZE  flit of input i at bits [i*SIZE +: SIZE].
REQ-008 SHALL have port out_req  output  1  two-phase request toward the shared channel, registered.
REQ-009 SHALL have port out_ack  input  1  two-phase acknowledge from the shared channel.
REQ-010 SHALL have port out_data  output  SIZE  forwarded flit, registered.
REQ-011 SHALL have port grant_id  output  3  index of the input currently or last served.
REQ-012 SHALL have port busy  output  1  high while a forwarded flit awaits out_ack.

Function
REQ-013 Input i SHALL count as pending when in_req[i] != in_ack[i]; the level compare is used, with no edge detector.
REQ-014 The controller SHALL have two states: IDLE and BUSY; busy SHALL equal (state == BUSY).
REQ-015 In IDLE with at least one pending input, the next edge SHALL do all of the following:
- select the winner by round-robin, searching from (last_grant+1) mod N upward with wrap-around;
- latch the winner's in_data slice into out_data;
- toggle out_req;
- set grant_id to the winner;
- enter BUSY.
REQ-016 In IDLE with no pending input, all outputs SHALL hold their values.
REQ-017 In BUSY, out_data, grant_id and out_req SHALL hold regardless of in_req or in_data activity.
REQ-018 In BUSY, the handshake SHALL complete when out_ack == out_req. On that edge the block SHALL:
- toggle in_ack[grant_id];
- set last_grant to grant_id;
- return to IDLE.
REQ-019 A missing out_ack SHALL hold BUSY indefinitely; there SHALL be no timeout.
REQ-020 The minimum spacing between successive out_req toggles SHALL be 2 cycles after ack completion, because the completion edge and the next IDLE evaluation occur on distinct edges. This ensures the just-acked input is not re-granted without a fresh in_req toggle.
REQ-021 Latency from an in_req toggle (sampled while IDLE) to the out_req toggle SHALL be 1 clock edge.
REQ-022 Requests arriving on any input while BUSY SHALL remain pending and be arbitrated on return to IDLE; no request SHALL be lost or counted twice.
REQ-023 An input toggling in_req again before receiving its in_ack SHALL be a protocol violation; its behaviour is unspecified, and the bench SHALL flag it.
REQ-024 With all N inputs continuously pending, each input SHALL be granted exactly once per N grants (strict rotation).
REQ-025 out_data SHALL carry the flit unmodified; the block SHALL perform no decoding of destination bits.

Reset
REQ-026 On reset assertion, the block SHALL immediately set:
- out_req = 0, out_data = 0, in_ack = 0;
- grant_id = 0, busy = 0, state = IDLE;
- last_grant = N-1, so input 0 has first priority.
REQ-027 Reset asserted mid-BUSY SHALL abandon the in-flight handshake, and no in_ack toggle SHALL be issued for it.
REQ-028 After reset release, the first grant SHALL occur no earlier than the first rising edge on which reset is low.

Verification
REQ-029 Single request: toggle in_req[2] 0->1 with slice 2 = 0x5A, IDLE -> next edge gives out_data=0x5A, out_req=1, grant_id=2, busy=1; then out_ack=1 -> next edge gives in_ack[2]=1, busy=0.
REQ-030 Simultaneous requests: after reset, toggle in_req[3:0] together with data 0x10, 0x21, 0x32, 0x43, acking each promptly -> out_data sequence 0x10, 0x21, 0x32, 0x43 and grant_id sequence 0, 1, 2, 3.
REQ-031 Fairness: inputs 1 and 3 re-request immediately after each in_ack -> grants alternate 1, 3, 1, 3 for at least 8 grants, and input 1 is never granted twice in a row.
REQ-032 Stalled channel: withhold out_ack for 50 cycles while in_data changes and other inputs toggle -> out_data, out_req and grant_id stay constant, busy=1, and no in_ack changes.
REQ-033 Reset mid-operation: assert reset while BUSY with grant_id=1 -> out_req=0, in_ack=0, busy=0 immediately; after release, the first grant goes to the lowest-index pending input.
REQ-034 Wrap-around: last_grant=3 (N=4) with inputs 0 and 2 pending -> the next grant goes to input 0, then to input 2.
